// File: rtl/keccak_padder_stream.sv
// rtl/keccak_padder_stream.sv - streaming Keccak pad10*1 padder packing W-bit words into RATE-bit blocks
module keccak_padder_stream #(
  parameter int unsigned W      = 64,
  parameter int unsigned RATE   = 576,
  parameter logic [7:0]  DSBYTE = 8'h06
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [W-1:0]           in,
  input  logic                   in_valid,
  input  logic                   is_last,
  input  logic [$clog2(W/8):0]   byte_num,
  output logic                   in_ready,
  output logic [RATE-1:0]        out,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ack
);

  localparam int unsigned N   = RATE / W;
  localparam int unsigned NB  = W / 8;
  localparam int unsigned CW  = $clog2(N + 1);
  localparam int unsigned BNW = $clog2(NB) + 1;

  localparam logic [CW-1:0]  CNT_FULL = CW'(N);
  localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
  localparam logic [BNW-1:0] BN_MAX   = BNW'(NB);

  localparam logic [1:0] S_ABSORB = 2'd0;
  localparam logic [1:0] S_PAD    = 2'd1;
  localparam logic [1:0] S_FULL   = 2'd2;

  logic [1:0]      state;
  logic [RATE-1:0] blk;
  logic [CW-1:0]   cnt;
  // pad_done: the 8'h80 terminator is already in the buffer
  logic            pad_done;
  // pending_ds: message ended on a word boundary, DSBYTE still owed
  logic            pending_ds;
  // msg_end: the block being assembled belongs to a finished message
  logic            msg_end;
  logic [BNW-1:0]  bn;
  logic [W-1:0]    last_word;
  logic [W-1:0]    pad_word;
  logic            accept;
  logic            last_slot;

  assign bn        = (byte_num > BN_MAX) ? BN_MAX : byte_num;
  assign last_slot = (cnt == CNT_LAST);
  assign in_ready  = (state == S_ABSORB) && (cnt < CNT_FULL);
  assign accept    = in_valid && in_ready;
  assign out       = blk;
  assign out_valid = (state == S_FULL);
  assign out_last  = (state == S_FULL) && pad_done;

  // Final partial word: keep bn data bytes from the MSB end, then DSBYTE, then zeros
  always_comb begin
    last_word = '0;
    for (int i = 0; i < NB; i++) begin
      if (BNW'(i) < bn) begin
        last_word[W-1-8*i -: 8] = in[W-1-8*i -: 8];
      end else if (BNW'(i) == bn) begin
        last_word[W-1-8*i -: 8] = DSBYTE;
      end
    end
    if (last_slot) begin
      last_word[7:0] = last_word[7:0] | 8'h80;
    end
  end

  // Padding word: owed DSBYTE at the MSB end, terminator in the LSB byte of the final slot
  always_comb begin
    pad_word = '0;
    if (pending_ds) begin
      pad_word[W-1 -: 8] = DSBYTE;
    end
    if (last_slot) begin
      pad_word[7:0] = pad_word[7:0] | 8'h80;
    end
  end

  // Absorb / pad / hand-off sequencing; a full buffer is offered on the edge after its last slot fills
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_ABSORB;
      blk        <= '0;
      cnt        <= '0;
      pad_done   <= 1'b0;
      pending_ds <= 1'b0;
      msg_end    <= 1'b0;
    end else begin
      case (state)
        S_ABSORB: begin
          if (cnt == CNT_FULL) begin
            state <= S_FULL;
          end else if (accept) begin
            cnt <= cnt + 1'b1;
            if (!is_last) begin
              blk <= {blk[RATE-W-1:0], in};
            end else if (bn != BN_MAX) begin
              blk        <= {blk[RATE-W-1:0], last_word};
              pad_done   <= last_slot;
              pending_ds <= 1'b0;
              msg_end    <= 1'b1;
              state      <= S_PAD;
            end else begin
              blk        <= {blk[RATE-W-1:0], in};
              pad_done   <= 1'b0;
              pending_ds <= 1'b1;
              msg_end    <= 1'b1;
              state      <= S_PAD;
            end
          end
        end
        S_PAD: begin
          if (cnt == CNT_FULL) begin
            state <= S_FULL;
          end else begin
            blk        <= {blk[RATE-W-1:0], pad_word};
            cnt        <= cnt + 1'b1;
            pending_ds <= 1'b0;
            if (last_slot) begin
              pad_done <= 1'b1;
            end
          end
        end
        S_FULL: begin
          if (out_ack) begin
            cnt <= '0;
            if (msg_end && !pad_done) begin
              state <= S_PAD;
            end else begin
              state    <= S_ABSORB;
              msg_end  <= 1'b0;
              pad_done <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_ABSORB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_padder_stream.sv
// tb/tb_keccak_padder_stream.sv - self-checking bench for keccak_padder_stream
module tb_keccak_padder_stream;

  typedef struct {
    logic [1087:0] data;
    logic          last;
  } blk_t;

  typedef struct {
    logic [63:0] d;
    logic        last;
    logic [3:0]  bn;
  } wrd_t;

  logic clk = 1'b0;
  logic reset_n;

  logic [63:0]  in0;
  logic         v0, last0, ack0, rdy0, ov0, ol0;
  logic [3:0]   bn0;
  logic [575:0] out0;

  logic [63:0]   in1;
  logic          v1, last1, ack1, rdy1, ov1, ol1;
  logic [3:0]    bn1;
  logic [1087:0] out1;

  int errors = 0;
  int checks = 0;

  blk_t        exp_q[$];
  wrd_t        wq[$];
  byte unsigned msg_bytes[$];

  keccak_padder_stream #(.W(64), .RATE(576), .DSBYTE(8'h06)) dut0 (
    .clk(clk), .reset_n(reset_n), .in(in0), .in_valid(v0), .is_last(last0),
    .byte_num(bn0), .in_ready(rdy0), .out(out0), .out_valid(ov0),
    .out_last(ol0), .out_ack(ack0)
  );

  keccak_padder_stream #(.W(64), .RATE(1088), .DSBYTE(8'h1F)) dut1 (
    .clk(clk), .reset_n(reset_n), .in(in1), .in_valid(v1), .is_last(last1),
    .byte_num(bn1), .in_ready(rdy1), .out(out1), .out_valid(ov1),
    .out_last(ol1), .out_ack(ack1)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [575:0] got, input logic [575:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: byte-level pad10*1 of the whole message, cut into rate-sized blocks
  task automatic model_msg(input int rb, input logic [7:0] ds);
    byte unsigned p[$];
    blk_t b;
    int idx;
    p = msg_bytes;
    p.push_back(ds);
    while (p.size() % rb != 0) p.push_back(8'h00);
    idx = p.size() - 1;
    p[idx] = p[idx] | 8'h80;
    for (int s = 0; s < p.size(); s += rb) begin
      b.data = '0;
      for (int k = 0; k < rb; k++) b.data[rb*8-1-8*k -: 8] = p[s+k];
      b.last = (s + rb == p.size());
      exp_q.push_back(b);
    end
  endtask

  task automatic gen_msg(input int nw);
    wrd_t w;
    int nb;
    msg_bytes.delete();
    for (int i = 0; i < nw; i++) begin
      w.d    = {$urandom, $urandom};
      w.last = (i == nw - 1);
      w.bn   = 4'($urandom_range(0, 15));
      nb     = w.last ? ((w.bn > 4'd8) ? 8 : int'(w.bn)) : 8;
      for (int k = 0; k < nb; k++) msg_bytes.push_back(w.d[63-8*k -: 8]);
      wq.push_back(w);
    end
    model_msg(72, 8'h06);
  endtask

  task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] bn);
    int t = 0;
    in0 = d; last0 = last; bn0 = bn; v0 = 1'b1;
    while (!rdy0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("send_ready", 576'(t < 100), 576'(1));
    @(posedge clk); #1;
    v0 = 1'b0;
  endtask

  task automatic wait_block(output int lat);
    lat = 0;
    while (!ov0 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("block_timeout", 576'(ov0), 576'(1));
  endtask

  task automatic ack_block();
    ack0 = 1'b1;
    @(posedge clk); #1;
    ack0 = 1'b0;
    chk("valid_drop_after_ack", 576'(ov0), 576'(0));
  endtask

  task automatic run_traffic(input int limit);
    int cyc = 0;
    bit hold = 0;
    bit consumed;
    logic [575:0] held_d;
    logic held_l;
    blk_t e;
    wrd_t w;
    v0 = 1'b0; ack0 = 1'b0;
    while ((wq.size() > 0 || exp_q.size() > 0 || v0) && cyc < limit) begin
      if (!v0 && wq.size() > 0 && $urandom_range(0, 3) != 0) begin
        w = wq.pop_front();
        in0 = w.d; last0 = w.last; bn0 = w.bn; v0 = 1'b1;
      end
      ack0 = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (ov0) begin
        if (hold) begin
          chk("rnd_hold_data", out0, held_d);
          chk("rnd_hold_last", 576'(ol0), 576'(held_l));
        end
        chk("rnd_ready_while_full", 576'(rdy0), 576'(0));
        if (ack0) begin
          if (exp_q.size() == 0) begin
            chk("rnd_unexpected_block", 576'(ov0), 576'(0));
          end else begin
            e = exp_q.pop_front();
            chk("rnd_data", out0, e.data[575:0]);
            chk("rnd_last", 576'(ol0), 576'(e.last));
          end
          hold = 0;
        end else begin
          hold = 1; held_d = out0; held_l = ol0;
        end
      end else begin
        hold = 0;
      end
      consumed = v0 && rdy0;
      @(posedge clk); #1;
      if (consumed) v0 = 1'b0;
      cyc++;
    end
    chk("rnd_drained", 576'(wq.size() + exp_q.size()), 576'(0));
    v0 = 1'b0; ack0 = 1'b0;
  endtask

  initial begin
    logic [575:0] e0, e, held;
    logic [63:0]  ws[9];
    logic [63:0]  x, wd;
    int lat;

    e0 = '0; e0[575:568] = 8'h06; e0[7:0] = 8'h80;
    reset_n = 1'b0;
    in0 = '0; v0 = 0; last0 = 0; bn0 = '0; ack0 = 0;
    in1 = '0; v1 = 0; last1 = 0; bn1 = '0; ack1 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 576'(ov0), 576'(0));
    chk("reset_out_last", 576'(ol0), 576'(0));
    chk("reset_out", out0, '0);
    chk("reset_out_valid_1088", 576'(ov1), 576'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", 576'(rdy0), 576'(1));

    // Empty message, garbage data bytes ignored
    send_word({$urandom, $urandom}, 1'b1, 4'd0);
    wait_block(lat);
    chk("empty_latency", 576'(lat), 576'(9));
    chk("empty_out", out0, e0);
    chk("empty_last", 576'(ol0), 576'(1));
    ack_block();

    // Nine full words: data block then a pure padding block
    wd = 64'h0123456789ABCDEF;
    for (int i = 0; i < 9; i++) send_word(wd, i == 8, 4'd8);
    wait_block(lat);
    chk("full9_out", out0, {9{wd}});
    chk("full9_last", 576'(ol0), 576'(0));
    ack_block();
    wait_block(lat);
    chk("full9_pad_out", out0, e0);
    chk("full9_pad_last", 576'(ol0), 576'(1));
    ack_block();

    // Seven-byte final word in the last slot shares DSBYTE and terminator
    for (int i = 0; i < 8; i++) begin
      ws[i] = {$urandom, $urandom};
      send_word(ws[i], 1'b0, 4'd0);
    end
    send_word(64'hAABBCCDDEEFF1122, 1'b1, 4'd7);
    wait_block(lat);
    chk("share_low_word", 576'(out0[63:0]), 576'(64'hAABBCCDDEEFF1186));
    chk("share_out", out0, {ws[0], ws[1], ws[2], ws[3], ws[4], ws[5], ws[6], ws[7],
                            64'hAABBCCDDEEFF1186});
    chk("share_last", 576'(ol0), 576'(1));
    ack_block();

    // Back-pressure: block held while a new word waits
    for (int i = 0; i < 9; i++) begin
      ws[i] = {$urandom, $urandom};
      send_word(ws[i], 1'b0, 4'd0);
    end
    wait_block(lat);
    held = out0;
    chk("bp_block", held, {ws[0], ws[1], ws[2], ws[3], ws[4], ws[5], ws[6], ws[7], ws[8]});
    x = {$urandom, $urandom};
    in0 = x; last0 = 1'b1; bn0 = 4'd3; v0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 576'(rdy0), 576'(0));
      chk("bp_out_stable", out0, held);
      chk("bp_valid", 576'(ov0), 576'(1));
      chk("bp_last", 576'(ol0), 576'(0));
    end
    ack0 = 1'b1;
    @(posedge clk); #1;
    ack0 = 1'b0;
    chk("bp_ready_after_ack", 576'(rdy0), 576'(1));
    @(posedge clk); #1;
    v0 = 1'b0;
    wait_block(lat);
    e = '0; e[575:552] = x[63:40]; e[551:544] = 8'h06; e[7:0] = 8'h80;
    chk("bp_next_block", out0, e);
    chk("bp_next_last", 576'(ol0), 576'(1));
    ack_block();

    // Oversized byte_num clamps to a full word
    x = {$urandom, $urandom};
    send_word(x, 1'b1, 4'd15);
    wait_block(lat);
    e = '0; e[575:512] = x; e[511:504] = 8'h06; e[7:0] = 8'h80;
    chk("clamp_out", out0, e);
    chk("clamp_last", 576'(ol0), 576'(1));
    ack_block();

    // Reset after four words discards the partial block
    for (int i = 0; i < 4; i++) send_word({$urandom, $urandom}, 1'b0, 4'd0);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", 576'(ov0), 576'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    send_word({$urandom, $urandom}, 1'b1, 4'd0);
    wait_block(lat);
    chk("rst_mid_latency", 576'(lat), 576'(9));
    chk("rst_mid_out", out0, e0);
    ack_block();

    // Reset while a block is offered drops out_valid without a clock edge
    for (int i = 0; i < 9; i++) send_word({$urandom, $urandom}, 1'b0, 4'd0);
    wait_block(lat);
    reset_n = 1'b0;
    #1;
    chk("rst_async_valid", 576'(ov0), 576'(0));
    chk("rst_async_out", out0, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // out_ack while nothing is offered is ignored
    send_word({$urandom, $urandom}, 1'b1, 4'd0);
    ack0 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    ack0 = 1'b0;
    wait_block(lat);
    chk("idle_ack_out", out0, e0);
    chk("idle_ack_last", 576'(ol0), 576'(1));
    ack_block();

    // Randomised back-to-back messages against the byte-level model
    for (int m = 0; m < 25; m++) gen_msg($urandom_range(1, 20));
    run_traffic(20000);

    // Wider rate with SHAKE domain byte
    in1 = {$urandom, $urandom}; last1 = 1'b1; bn1 = 4'd0; v1 = 1'b1;
    lat = 0;
    while (!rdy1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("r1088_ready", 576'(rdy1), 576'(1));
    @(posedge clk); #1;
    v1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("r1088_latency", 576'(lat), 576'(17));
    chk("r1088_out_hi", 576'(out1[1087:576]), 576'({8'h1F, 504'h0}));
    chk("r1088_out_lo", out1[575:0], {568'h0, 8'h80});
    chk("r1088_last", 576'(ol1), 576'(1));
    ack1 = 1'b1;
    @(posedge clk); #1;
    ack1 = 1'b0;
    chk("r1088_valid_drop", 576'(ov1), 576'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
